// File: rtl/clk_div_pkg.sv
// Shared types and constants for the clock divider bank.
package clk_div_pkg;

  localparam int DEF_CNT_W = 8;
  localparam int MAX_CH    = 8;
  localparam int RATIO_OFF = 0;

  typedef logic [DEF_CNT_W-1:0] ratio_t;

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/shadow ratio, pending flag, registered clk_out and tick.
// Optional phase alignment input sync_start when CLK_DIV_PHASE_ALIGN_EN is defined.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
`ifdef CLK_DIV_PHASE_ALIGN_EN
  input  logic             sync_start,
`endif
  input  logic             load,
  input  logic [CNT_W-1:0] load_ratio,
  output logic             pending,
  output logic             clk_out,
  output logic             tick
);

  localparam logic [CNT_W-1:0] DEF_R = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] OFF   = CNT_W'(RATIO_OFF);

  logic [CNT_W-1:0] ratio, cnt, shadow;
  logic [CNT_W-1:0] ratio_next, cnt_next;
  logic [CNT_W:0]   half;
  logic             sync, boundary, apply, clk_out_next, tick_next;

  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    sync = 1'b0;
`ifdef CLK_DIV_PHASE_ALIGN_EN
    sync = sync_start;
`endif
    // A stopped channel (R=0) is always at a boundary so a new ratio loads at once.
    boundary   = (ratio == OFF) || (cnt == ratio - 1'b1);
    apply      = en && pending && (sync || boundary);
    ratio_next = apply ? shadow : ratio;

    if (sync || apply || ratio_next == OFF)
      cnt_next = '0;
    else if (cnt == ratio_next - 1'b1)
      cnt_next = '0;
    else
      cnt_next = cnt + 1'b1;

    // (R+1)/2 carries an extra bit so a full-scale ratio does not wrap.
    half         = ({1'b0, ratio_next} + 1'b1) >> 1;
    clk_out_next = (ratio_next != OFF) && ({1'b0, cnt_next} < half);
    tick_next    = (ratio_next != OFF) && (cnt_next == ratio_next - 1'b1);
  end

  // NOTE: state uses non-blocking assignments; the reset is synchronous, so it is
  // simply the first branch inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      ratio   <= DEF_R;
      shadow  <= DEF_R;
      cnt     <= '0;
      pending <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
    end else begin
      if (en) begin
        ratio   <= ratio_next;
        cnt     <= cnt_next;
        clk_out <= clk_out_next;
        tick    <= tick_next;
        if (apply) pending <= 1'b0;
      end else begin
        tick <= 1'b0;
      end
      // Loads only happen while nothing is pending, so this never races an apply.
      if (load) begin
        shadow  <= load_ratio;
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH clock dividers sharing one div_cfg handshake.
// Define CLK_DIV_PHASE_ALIGN_EN to add the sync_start phase-alignment input.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_n,
  input  logic                    en,
`ifdef CLK_DIV_PHASE_ALIGN_EN
  input  logic                    sync_start,
`endif
  input  logic [NUM_CH*CNT_W-1:0] div_cfg,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick
);

  logic [NUM_CH-1:0] pending;
  logic              accept;

  // Ready rises the cycle after the last channel clears its pending flag.
  assign cfg_ready = ~|pending;
  assign accept    = cfg_valid && cfg_ready;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_channel #(
      .CNT_W      (CNT_W),
      .DEFAULT_DIV(DEFAULT_DIV)
    ) u_ch (
      .clk_in     (clk_in),
      .rst_n      (rst_n),
      .en         (en),
`ifdef CLK_DIV_PHASE_ALIGN_EN
      .sync_start (sync_start),
`endif
      .load       (accept),
      .load_ratio (div_cfg[i*CNT_W +: CNT_W]),
      .pending    (pending[i]),
      .clk_out    (clk_out[i]),
      .tick       (tick[i])
    );
  end

endmodule
